// File: rtl/rename_map_pkg.sv
// Shared types and defaults for the rename_map register-rename stage.
// Optional feature macro: RENAME_ZERO_REG_EN (architectural reg 0 hardwired to physical 0).
package rename_map_pkg;

  localparam int ARCH_REGS_DEF = 16;
  localparam int PHYS_REGS_DEF = 32;
  localparam int AW_DEF        = $clog2(ARCH_REGS_DEF);
  localparam int PW_DEF        = $clog2(PHYS_REGS_DEF);

`ifdef RENAME_ZERO_REG_EN
  localparam bit ZERO_REG_EN = 1'b1;
`else
  localparam bit ZERO_REG_EN = 1'b0;
`endif

  typedef logic [AW_DEF-1:0] arch_reg_t;
  typedef logic [PW_DEF-1:0] phys_reg_t;

  typedef struct packed {
    logic      wr;
    arch_reg_t rd;
    arch_reg_t rs1;
    arch_reg_t rs2;
  } rename_req_t;

  typedef struct packed {
    logic      wr;
    phys_reg_t prd;
    phys_reg_t old_prd;
    phys_reg_t prs1;
    phys_reg_t prs2;
  } renamed_t;

  localparam int RENAMED_INSTRUCTION_WIDTH = $bits(renamed_t);

  // True when the given architectural index is the hardwired zero register.
  function automatic logic is_hardwired(input logic [31:0] idx);
    return (idx == 32'd0) && ZERO_REG_EN;
  endfunction

endpackage

// File: rtl/rename_map_if.sv
// Decode / issue / commit / flush signal bundle of the rename_map stage.
interface rename_map_if #(
  parameter int ARCH_REGS = rename_map_pkg::ARCH_REGS_DEF,
  parameter int PHYS_REGS = rename_map_pkg::PHYS_REGS_DEF
);
  localparam int AW = $clog2(ARCH_REGS);
  localparam int PW = $clog2(PHYS_REGS);

  logic          decoded_v_i;
  logic          dec_wr_i;
  logic [AW-1:0] dec_rd_i;
  logic [AW-1:0] dec_rs1_i;
  logic [AW-1:0] dec_rs2_i;
  logic          rename_decode_ready_o;
  logic          renamed_v_o;
  logic          ren_wr_o;
  logic [PW-1:0] ren_prd_o;
  logic [PW-1:0] ren_old_prd_o;
  logic [PW-1:0] ren_prs1_o;
  logic [PW-1:0] ren_prs2_o;
  logic          issue_rename_ready_i;
  logic          commit_v_i;
  logic          commit_wr_i;
  logic [AW-1:0] commit_rd_i;
  logic [PW-1:0] commit_prd_i;
  logic [PW-1:0] commit_old_prd_i;
  logic          mispredict_i;
  logic [PW:0]   free_count_o;

  modport master (
    output decoded_v_i, dec_wr_i, dec_rd_i, dec_rs1_i, dec_rs2_i,
    output issue_rename_ready_i, commit_v_i, commit_wr_i, commit_rd_i,
    output commit_prd_i, commit_old_prd_i, mispredict_i,
    input  rename_decode_ready_o, renamed_v_o, ren_wr_o, ren_prd_o,
    input  ren_old_prd_o, ren_prs1_o, ren_prs2_o, free_count_o
  );

  modport slave (
    input  decoded_v_i, dec_wr_i, dec_rd_i, dec_rs1_i, dec_rs2_i,
    input  issue_rename_ready_i, commit_v_i, commit_wr_i, commit_rd_i,
    input  commit_prd_i, commit_old_prd_i, mispredict_i,
    output rename_decode_ready_o, renamed_v_o, ren_wr_o, ren_prd_o,
    output ren_old_prd_o, ren_prs1_o, ren_prs2_o, free_count_o
  );
endinterface

// File: rtl/rename_free_alloc.sv
// Lowest-set-bit priority encoder plus popcount over the free-list vector.
module rename_free_alloc #(
  parameter int N  = 32,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic [IW-1:0] idx,
  output logic          found,
  output logic [IW:0]   count
);

  // Scan high to low so the last hit is the lowest index.
  always_comb begin
    idx   = {IW{1'b0}};
    count = {(IW+1){1'b0}};
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = IW'(i);
      end else begin
        idx = idx;
      end
      count = count + {{IW{1'b0}}, vec[i]};
    end
    found = |vec;
  end

endmodule

// File: rtl/rename_map.sv
// Register-rename stage: speculative/architectural RATs, bit-vector free list, 1-cycle output.
// Optional feature macro: RENAME_ZERO_REG_EN (see rename_map_pkg::is_hardwired).
module rename_map
  import rename_map_pkg::*;
#(
  parameter int ARCH_REGS = ARCH_REGS_DEF,
  parameter int PHYS_REGS = PHYS_REGS_DEF
) (
  input logic         clk_i,
  input logic         reset_i,
  rename_map_if.slave bus
);

  localparam int AW = $clog2(ARCH_REGS);
  localparam int PW = $clog2(PHYS_REGS);

  typedef struct packed {
    logic          wr;
    logic [PW-1:0] prd;
    logic [PW-1:0] old_prd;
    logic [PW-1:0] prs1;
    logic [PW-1:0] prs2;
  } ren_fields_t;

  logic [PW-1:0]        spec_rat_r      [ARCH_REGS];
  logic [PW-1:0]        arch_rat_r      [ARCH_REGS];
  logic [PW-1:0]        spec_rat_next_s [ARCH_REGS];
  logic [PW-1:0]        arch_rat_next_s [ARCH_REGS];
  logic [PHYS_REGS-1:0] arch_alloc_r, arch_alloc_next_s;
  logic [PHYS_REGS-1:0] free_r, free_next_s;
  logic                 ren_valid_r;
  ren_fields_t          ren_r, ren_next_s;

  logic [PW-1:0] alloc_idx_s;
  logic          alloc_found_s;
  logic [PW:0]   free_cnt_s;
  logic          ready_s, fire_s, alloc_s, commit_en_s;

  rename_free_alloc #(.N(PHYS_REGS), .IW(PW)) u_free_alloc (
    .vec   (free_r),
    .idx   (alloc_idx_s),
    .found (alloc_found_s),
    .count (free_cnt_s)
  );

  // Handshake and the fields of the instruction being renamed this cycle.
  always_comb begin
    ready_s     = (!ren_valid_r || bus.issue_rename_ready_i) && alloc_found_s && !bus.mispredict_i;
    fire_s      = bus.decoded_v_i && ready_s;
    alloc_s     = fire_s && bus.dec_wr_i && !is_hardwired(32'(bus.dec_rd_i));
    commit_en_s = bus.commit_v_i && bus.commit_wr_i && !is_hardwired(32'(bus.commit_rd_i));

    ren_next_s.wr      = bus.dec_wr_i && !is_hardwired(32'(bus.dec_rd_i));
    ren_next_s.prd     = alloc_s ? alloc_idx_s : {PW{1'b0}};
    ren_next_s.old_prd = alloc_s ? spec_rat_r[bus.dec_rd_i] : {PW{1'b0}};
    ren_next_s.prs1    = is_hardwired(32'(bus.dec_rs1_i)) ? {PW{1'b0}} : spec_rat_r[bus.dec_rs1_i];
    ren_next_s.prs2    = is_hardwired(32'(bus.dec_rs2_i)) ? {PW{1'b0}} : spec_rat_r[bus.dec_rs2_i];
  end

  // Next committed state; a flush restores from this so same-cycle commits are kept.
  always_comb begin
    arch_rat_next_s   = arch_rat_r;
    arch_alloc_next_s = arch_alloc_r;
    if (commit_en_s) begin
      arch_rat_next_s[bus.commit_rd_i]        = bus.commit_prd_i;
      arch_alloc_next_s[bus.commit_old_prd_i] = 1'b0;
      arch_alloc_next_s[bus.commit_prd_i]     = 1'b1;
    end else begin
      arch_alloc_next_s = arch_alloc_r;
    end
  end

  // Next speculative state; mispredict wins over any allocation.
  always_comb begin
    spec_rat_next_s = spec_rat_r;
    free_next_s     = free_r;
    if (bus.mispredict_i) begin
      spec_rat_next_s = arch_rat_next_s;
      free_next_s     = ~arch_alloc_next_s;
    end else begin
      if (alloc_s) begin
        spec_rat_next_s[bus.dec_rd_i] = alloc_idx_s;
        free_next_s[alloc_idx_s]      = 1'b0;
      end else begin
        spec_rat_next_s = spec_rat_r;
      end
      if (commit_en_s) begin
        free_next_s[bus.commit_old_prd_i] = 1'b1;
      end else begin
        free_next_s = free_next_s;
      end
    end
    free_next_s[0] = free_next_s[0] && !is_hardwired(32'd0);
  end

  // Rename tables and free list.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        spec_rat_r[i] <= PW'(i);
        arch_rat_r[i] <= PW'(i);
      end
      arch_alloc_r <= {{(PHYS_REGS-ARCH_REGS){1'b0}}, {ARCH_REGS{1'b1}}};
      free_r       <= {{(PHYS_REGS-ARCH_REGS){1'b1}}, {ARCH_REGS{1'b0}}};
    end else begin
      spec_rat_r   <= spec_rat_next_s;
      arch_rat_r   <= arch_rat_next_s;
      arch_alloc_r <= arch_alloc_next_s;
      free_r       <= free_next_s;
    end
  end

  // Output register: loads on fire, holds while issue stalls.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ren_valid_r <= 1'b0;
      ren_r       <= {$bits(ren_fields_t){1'b0}};
    end else if (bus.mispredict_i) begin
      ren_valid_r <= 1'b0;
    end else if (fire_s) begin
      ren_valid_r <= 1'b1;
      ren_r       <= ren_next_s;
    end else if (bus.issue_rename_ready_i) begin
      ren_valid_r <= 1'b0;
    end else begin
      ren_valid_r <= ren_valid_r;
    end
  end

  assign bus.rename_decode_ready_o = ready_s;
  assign bus.renamed_v_o           = ren_valid_r;
  assign bus.ren_wr_o              = ren_r.wr;
  assign bus.ren_prd_o             = ren_r.prd;
  assign bus.ren_old_prd_o         = ren_r.old_prd;
  assign bus.ren_prs1_o            = ren_r.prs1;
  assign bus.ren_prs2_o            = ren_r.prs2;
  assign bus.free_count_o          = free_cnt_s;

endmodule

// File: tb/tb_rename_map.sv
// Self-checking bench for rename_map: directed scenarios plus random traffic against a map/set model.
module tb_rename_map;

  localparam int ARCH = 16;
  localparam int PHYS = 32;
`ifdef RENAME_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_i = 1'b1;
  always #5 clk = ~clk;

  rename_map_if #(.ARCH_REGS(ARCH), .PHYS_REGS(PHYS)) bus ();
  rename_map #(.ARCH_REGS(ARCH), .PHYS_REGS(PHYS)) dut (.clk_i(clk), .reset_i(reset_i), .bus(bus));

  int vec_cnt = 0;
  int miss_cnt = 0;

  // stimulus for the current cycle
  logic dv, dw, iss, cv, cw, mp;
  logic [3:0] rd, rs1, rs2, crd;
  logic [4:0] cprd, cold;

  // reference model
  int spec_map [ARCH];
  int arch_map [ARCH];
  bit free_b [PHYS];
  bit owned [PHYS];
  bit m_v, m_wr;
  int m_rd, m_prd, m_old, m_prs1, m_prs2;
  typedef struct { bit wr; int rd; int prd; int old; } rec_t;
  rec_t pend [$];

  task automatic check(input string tag, input longint obs, input longint exp);
    vec_cnt++;
    if (obs != exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int m_free_cnt();
    int n = 0;
    for (int p = 0; p < PHYS; p++) n += int'(free_b[p]);
    return n;
  endfunction

  function automatic bit m_ready();
    return (!m_v || iss) && (m_free_cnt() > 0) && !mp;
  endfunction

  task automatic model_reset();
    for (int a = 0; a < ARCH; a++) begin spec_map[a] = a; arch_map[a] = a; end
    for (int p = 0; p < PHYS; p++) begin owned[p] = (p < ARCH); free_b[p] = (p >= ARCH); end
    m_v = 0; m_wr = 0; m_rd = 0; m_prd = 0; m_old = 0; m_prs1 = 0; m_prs2 = 0;
    pend.delete();
  endtask

  task automatic model_next();
    bit fire, alloc, rd_zero;
    int lo;
    rec_t r;
    fire = dv && m_ready();
    rd_zero = ZR && (rd == 4'd0);
    alloc = fire && dw && !rd_zero;
    lo = -1;
    for (int p = PHYS - 1; p >= 0; p--) if (free_b[p]) lo = p;
    if (m_v && iss && !mp) begin
      r.wr = m_wr; r.rd = m_rd; r.prd = m_prd; r.old = m_old;
      pend.push_back(r);
    end
    if (fire) begin
      m_wr = dw && !rd_zero;
      m_rd = int'(rd);
      m_prs1 = (ZR && rs1 == 4'd0) ? 0 : spec_map[rs1];
      m_prs2 = (ZR && rs2 == 4'd0) ? 0 : spec_map[rs2];
      m_prd = alloc ? lo : 0;
      m_old = alloc ? spec_map[rd] : 0;
      m_v = 1;
      if (alloc) begin free_b[lo] = 0; spec_map[rd] = lo; end
    end else if (iss || mp) begin
      m_v = 0;
    end
    if (cv && cw && !(ZR && crd == 4'd0)) begin
      arch_map[crd] = int'(cprd);
      owned[cold] = 0;
      owned[cprd] = 1;
      free_b[cold] = 1;
    end
    if (mp) begin
      for (int a = 0; a < ARCH; a++) spec_map[a] = arch_map[a];
      for (int p = 0; p < PHYS; p++) free_b[p] = !owned[p];
      pend.delete();
    end
    if (ZR) free_b[0] = 0;
  endtask

  task automatic idle();
    dv = 0; dw = 0; rd = 4'd0; rs1 = 4'd0; rs2 = 4'd0; iss = 1;
    cv = 0; cw = 0; crd = 4'd0; cprd = 5'd0; cold = 5'd0; mp = 0;
  endtask

  task automatic drive();
    bus.decoded_v_i = dv; bus.dec_wr_i = dw; bus.dec_rd_i = rd;
    bus.dec_rs1_i = rs1; bus.dec_rs2_i = rs2; bus.issue_rename_ready_i = iss;
    bus.commit_v_i = cv; bus.commit_wr_i = cw; bus.commit_rd_i = crd;
    bus.commit_prd_i = cprd; bus.commit_old_prd_i = cold; bus.mispredict_i = mp;
  endtask

  // one clock: apply inputs, check ready, advance model, check registered outputs
  task automatic tick();
    drive();
    #2;
    check("ready", bus.rename_decode_ready_o, m_ready());
    model_next();
    @(posedge clk); #1;
    check("valid", bus.renamed_v_o, m_v);
    check("wr", bus.ren_wr_o, m_wr);
    check("prd", bus.ren_prd_o, m_prd);
    check("old_prd", bus.ren_old_prd_o, m_old);
    check("prs1", bus.ren_prs1_o, m_prs1);
    check("prs2", bus.ren_prs2_o, m_prs2);
    check("free_count", bus.free_count_o, m_free_cnt());
  endtask

  task automatic do_reset();
    idle(); drive();
    reset_i = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_i = 1'b0;
    model_reset();
    check("rst_valid", bus.renamed_v_o, 0);
    check("rst_prd", bus.ren_prd_o, 0);
    check("rst_free", bus.free_count_o, PHYS - ARCH);
  endtask

  task automatic wr_op(input logic [3:0] d, input logic [3:0] s1, input logic [3:0] s2);
    idle(); dv = 1; dw = 1; rd = d; rs1 = s1; rs2 = s2;
    tick();
  endtask

  initial begin
    idle(); drive();

    // fill the free list: rd = 1..15 then 0, then a stalled 17th write
    do_reset();
    for (int k = 0; k < 15; k++) begin
      wr_op(4'(k + 1), 4'd0, 4'd0);
      check("fill_prd", bus.ren_prd_o, 16 + k);
      check("fill_old", bus.ren_old_prd_o, k + 1);
    end
    wr_op(4'd0, 4'd0, 4'd0);
`ifndef RENAME_ZERO_REG_EN
    check("fill_last_prd", bus.ren_prd_o, 31);
    check("fill_empty", bus.free_count_o, 0);
    check("fill_stall", bus.rename_decode_ready_o, 0);
`endif
    wr_op(4'd7, 4'd0, 4'd0);

    // back-to-back dependency and rs == rd
    do_reset();
    wr_op(4'd3, 4'd0, 4'd0);
    idle(); dv = 1; rs1 = 4'd3; rs2 = 4'd3; tick();
    check("dep_prs1", bus.ren_prs1_o, 16);
    check("dep_prs2", bus.ren_prs2_o, 16);
    wr_op(4'd5, 4'd5, 4'd0);
    check("self_prs1", bus.ren_prs1_o, 5);
    check("self_prd", bus.ren_prd_o, 17);

    // issue back-pressure holds the output
    for (int k = 0; k < 4; k++) begin
      idle(); dv = 1; dw = 1; rd = 4'd6; iss = 0; tick();
      check("hold_prd", bus.ren_prd_o, 17);
    end
    wr_op(4'd6, 4'd0, 4'd0);
    check("release_prd", bus.ren_prd_o, 18);

    // commit frees the superseded mapping
    do_reset();
    wr_op(4'd2, 4'd0, 4'd0);
    idle(); cv = 1; cw = 1; crd = 4'd2; cprd = 5'd16; cold = 5'd2; tick();
    check("commit_free", bus.free_count_o, 16);
    wr_op(4'd9, 4'd0, 4'd0);
    check("reuse_prd", bus.ren_prd_o, 2);

    // mispredict with same-cycle commit
    do_reset();
    wr_op(4'd4, 4'd0, 4'd0);
    wr_op(4'd5, 4'd0, 4'd0);
    idle(); dv = 1; dw = 1; rd = 4'd7; mp = 1;
    cv = 1; cw = 1; crd = 4'd4; cprd = 5'd16; cold = 5'd4; tick();
    check("flush_valid", bus.renamed_v_o, 0);
    idle(); dv = 1; rs1 = 4'd5; rs2 = 4'd4; tick();
    check("flush_prs1", bus.ren_prs1_o, 5);
    check("flush_prs2", bus.ren_prs2_o, 16);
    wr_op(4'd8, 4'd0, 4'd0);
    check("flush_alloc", bus.ren_prd_o, 4);

`ifdef RENAME_ZERO_REG_EN
    do_reset();
    wr_op(4'd0, 4'd0, 4'd0);
    check("zr_prd", bus.ren_prd_o, 0);
    check("zr_wr", bus.ren_wr_o, 0);
    check("zr_free", bus.free_count_o, 16);
    idle(); dv = 1; rs1 = 4'd0; tick();
    check("zr_prs1", bus.ren_prs1_o, 0);
`endif

    // random traffic with in-order commits of issued instructions
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rec_t r;
      dv = ($urandom_range(0, 99) < 70);
      dw = ($urandom_range(0, 99) < 80);
      rd = 4'($urandom); rs1 = 4'($urandom); rs2 = 4'($urandom);
      iss = ($urandom_range(0, 99) < 75);
      mp = ($urandom_range(0, 99) < 3);
      if (pend.size() > 0 && $urandom_range(0, 99) < 40) begin
        r = pend.pop_front();
        cv = 1; cw = r.wr; crd = 4'(r.rd); cprd = 5'(r.prd); cold = 5'(r.old);
      end else begin
        cv = 0; cw = 1'($urandom); crd = 4'($urandom); cprd = 5'($urandom); cold = 5'($urandom);
      end
      tick();
    end

    idle(); drive();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
